control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle control unit that sequences the single-cycle CPU datapath (register file, ALU, mux_0/1/2, data memory).
- Accepts one 32-bit RV64 instruction per handshake and decodes it.
- Drives every datapath control input over a fixed per-class state sequence.
- Reports retirement, branch outcome and illegal opcodes. Instruction fetch and the PC register are outside this block.

Parameters:
- WORDSIZE, 64, datapath width; width of the generated immediate.
- COUNTWIDTH, 32, width of the retired-instruction counter.

Ports:
- cu_clk  input  1  clock; all state changes on the rising edge.
- cu_rst_n  input  1  synchronous, active-low reset.
- cu_instr  input  32  instruction word.
- cu_instr_valid  input  1  cu_instr is valid.
- cu_instr_ready  output  1  block can accept an instruction.
- cu_alu_zero  input  1  ALU result == 0, sampled in EXEC.
- cu_rf_addr_a  output  5  rs1 (instr[19:15]).
- cu_rf_addr_b  output  5  rs2 (instr[24:20]).
- cu_rf_write_addr  output  5  rd (instr[11:7]).
- cu_rf_write_en  output  1  register file write enable.
- cu_immediate  output  WORDSIZE  sign-extended immediate.
- cu_mux_0_sel  output  1  ALU A source: 0 = rf_data_a, 1 = PC.
- cu_mux_1_sel  output  1  ALU B source: 0 = immediate, 1 = rf_data_b.
- cu_mux_2_sel  output  1  writeback source: 0 = ALU result, 1 = dm_data_output.
- cu_alu_operation  output  3  000 add, 001 sub, 010 and, 011 or.
- cu_dm_write_en  output  1  data memory write enable.
- cu_pc_en  output  1  one-cycle pulse: advance PC (retire).
- cu_branch_taken  output  1  one-cycle pulse with cu_pc_en: PC <= PC + immediate.
- cu_illegal  output  1  one-cycle pulse: unsupported instruction dropped.
- cu_retired_count  output  COUNTWIDTH  instructions retired since reset.

Behaviour:

Reset:
- cu_rst_n == 0 at a rising edge: state <= IDLE, instruction register <= 0, counter <= 0.
- All outputs read 0 in the cycle after reset, except cu_instr_ready = 1.
- Reset takes effect mid-operation too. The in-flight instruction is abandoned, and no write enable or pulse is asserted after the reset edge.

States: IDLE, DECODE, EXEC, MEM, WB.

Handshake and state sequence:
- cu_instr_ready = 1 only in IDLE.
- Accept occurs on an edge where valid and ready are both 1 (call it edge 0). cu_instr is latched; cu_instr is don't-care in every other state.
- After an accept: IDLE -> DECODE.
- DECODE -> EXEC for legal opcodes.
- DECODE -> IDLE for illegal opcodes, with cu_illegal = 1 during that DECODE cycle. The counter does not increment.

Supported instructions, state sequences and control values:
- ld (opcode 0000011, funct3 011): DECODE -> EXEC -> MEM -> WB -> IDLE.
  - I-immediate; mux_1 = 0; alu = add.
  - WB: mux_2 = 1, rf_write_en = 1.
- sd (0100011, funct3 011): DECODE -> EXEC -> MEM -> IDLE.
  - S-immediate; mux_1 = 0; alu = add.
  - dm_write_en = 1 only in MEM.
- addi (0010011, funct3 000): DECODE -> EXEC -> WB -> IDLE.
  - mux_1 = 0, mux_2 = 0, add.
- R-type (0110011), DECODE -> EXEC -> WB -> IDLE, with mux_1 = 1 and mux_2 = 0:
  - add: funct7 0000000, funct3 000.
  - sub: funct7 0100000, funct3 000.
  - and: funct3 111.
  - or: funct3 110.
- beq (1100011, funct3 000): DECODE -> EXEC -> IDLE.
  - B-immediate; mux_1 = 1; alu = sub.
  - In EXEC: cu_branch_taken = cu_alu_zero.
- Any other opcode/funct combination is illegal.

Output timing:
- Address fields, immediate, mux selects and alu_operation are driven from the latched instruction in DECODE through the final state. They are held stable and read 0 in IDLE.
- cu_rf_write_en is asserted only in WB, and is forced to 0 when rd == 0.
- cu_pc_en pulses in the final state of each legal instruction: WB, MEM for sd, EXEC for beq.
- cu_retired_count increments on the edge ending that state and wraps modulo 2^COUNTWIDTH.
- mux_0_sel is always 0 for the supported set (the PC source is reserved).

Immediates (sign-extended to WORDSIZE):
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.

Throughput and latency:
- The next accept is possible on the edge after the return to IDLE.
- Latency from accept to writeback edge: ALU instructions 3 edges, ld 4 edges.

Test Plan:
1. Load, ld x2,5(x7) = 0x0053B103:
   - ready drops after edge 0.
   - addr_a = 7, write_addr = 2, immediate = 0x5, mux_1 = 0, alu = 000.
   - rf_write_en = 1 and mux_2 = 1 only in cycle 4.
   - pc_en pulses once; count = 1; ready returns after edge 4.
2. R-type pair, add x3,x1,x2 = 0x002081B3 then sub = 0x402081B3:
   - mux_1 = 1 for both.
   - alu = 000 then 001.
   - write_addr = 3, rf_write_en in cycle 3 of each; count = 2.
3. Store, sd x5,-8(x6) = 0xFE533C23:
   - immediate = 0xFFFF_FFFF_FFFF_FFF8, addr_a = 6, addr_b = 5.
   - dm_write_en = 1 for exactly one cycle (MEM).
   - rf_write_en never 1.
4. Branch, beq x1,x2,+16 = 0x00208863:
   - Run once with cu_alu_zero = 1 in EXEC: immediate = 0x10, branch_taken = 1 with pc_en.
   - Run again with zero = 0: pc_en = 1, branch_taken = 0.
5. Illegal and x0:
   - 0x00000000 -> cu_illegal pulse in DECODE, back in IDLE after 2 edges, count unchanged.
   - addi x0,x1,1 = 0x00108013 -> rf_write_en stays 0, pc_en pulses.
6. Reset mid-operation:
   - Assert cu_rst_n = 0 during MEM of an sd: no dm_write_en after the reset edge.
   - All outputs 0, ready = 1, count = 0.
   - valid held low while in IDLE -> no state change.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle control unit: latches one RV64 instruction per handshake and
// sequences the register file, ALU, muxes and data memory through its states.
module control_unit #(
    parameter int WORDSIZE   = 64,
    parameter int COUNTWIDTH = 32
) (
    input  logic                  cu_clk,
    input  logic                  cu_rst_n,
    input  logic [31:0]           cu_instr,
    input  logic                  cu_instr_valid,
    output logic                  cu_instr_ready,
    input  logic                  cu_alu_zero,
    output logic [4:0]            cu_rf_addr_a,
    output logic [4:0]            cu_rf_addr_b,
    output logic [4:0]            cu_rf_write_addr,
    output logic                  cu_rf_write_en,
    output logic [WORDSIZE-1:0]   cu_immediate,
    output logic                  cu_mux_0_sel,
    output logic                  cu_mux_1_sel,
    output logic                  cu_mux_2_sel,
    output logic [2:0]            cu_alu_operation,
    output logic                  cu_dm_write_en,
    output logic                  cu_pc_en,
    output logic                  cu_branch_taken,
    output logic                  cu_illegal,
    output logic [COUNTWIDTH-1:0] cu_retired_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_instr;
    logic [COUNTWIDTH-1:0] r_count;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic       w_is_ld;
    logic       w_is_sd;
    logic       w_is_addi;
    logic       w_is_r;
    logic       w_is_beq;
    logic       w_legal;
    logic       w_active;
    logic       w_final;
    logic [4:0] w_rd;

    logic [WORDSIZE-1:0] w_imm_i;
    logic [WORDSIZE-1:0] w_imm_s;
    logic [WORDSIZE-1:0] w_imm_b;

    assign w_opcode = r_instr[6:0];
    assign w_funct3 = r_instr[14:12];
    assign w_funct7 = r_instr[31:25];
    assign w_rd     = r_instr[11:7];

    assign w_is_ld   = (w_opcode == 7'b0000011) && (w_funct3 == 3'b011);
    assign w_is_sd   = (w_opcode == 7'b0100011) && (w_funct3 == 3'b011);
    assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
    assign w_is_beq  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b000);
    assign w_is_r    = (w_opcode == 7'b0110011) &&
                       (((w_funct3 == 3'b000) &&
                         ((w_funct7 == 7'b0000000) ||
                          (w_funct7 == 7'b0100000))) ||
                        (w_funct3 == 3'b111) ||
                        (w_funct3 == 3'b110));
    assign w_legal   = w_is_ld | w_is_sd | w_is_addi | w_is_r | w_is_beq;

    assign w_imm_i = {{(WORDSIZE-12){r_instr[31]}}, r_instr[31:20]};
    assign w_imm_s = {{(WORDSIZE-12){r_instr[31]}},
                      r_instr[31:25], r_instr[11:7]};
    assign w_imm_b = {{(WORDSIZE-13){r_instr[31]}}, r_instr[31],
                      r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};

    assign w_active = (r_state != S_IDLE);
    // Last state of every legal class; only legal instructions get here
    assign w_final  = (r_state == S_WB) ||
                      ((r_state == S_MEM) && w_is_sd) ||
                      ((r_state == S_EXEC) && w_is_beq);

    always_ff @(posedge cu_clk) begin
        if (!cu_rst_n) begin
            r_state <= S_IDLE;
            r_instr <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && cu_instr_valid) begin
                r_instr <= cu_instr;
            end
            if (w_final) begin
                r_count <= r_count + COUNTWIDTH'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (cu_instr_valid) w_next = S_DECODE;
            S_DECODE: w_next = w_legal ? S_EXEC : S_IDLE;
            S_EXEC: begin
                if (w_is_beq) begin
                    w_next = S_IDLE;
                end else if (w_is_ld || w_is_sd) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM:    w_next = w_is_ld ? S_WB : S_IDLE;
            S_WB:     w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        cu_instr_ready   = (r_state == S_IDLE);
        cu_rf_addr_a     = '0;
        cu_rf_addr_b     = '0;
        cu_rf_write_addr = '0;
        cu_rf_write_en   = 1'b0;
        cu_immediate     = '0;
        cu_mux_0_sel     = 1'b0;
        cu_mux_1_sel     = 1'b0;
        cu_mux_2_sel     = 1'b0;
        cu_alu_operation = ALU_ADD;
        cu_dm_write_en   = 1'b0;
        cu_pc_en         = w_final;
        cu_branch_taken  = 1'b0;
        cu_illegal       = (r_state == S_DECODE) && !w_legal;
        cu_retired_count = r_count;

        if (w_active) begin
            cu_rf_addr_a     = r_instr[19:15];
            cu_rf_addr_b     = r_instr[24:20];
            cu_rf_write_addr = w_rd;
            cu_mux_1_sel     = w_is_r | w_is_beq;

            unique case (1'b1)
                w_is_ld, w_is_addi: cu_immediate = w_imm_i;
                w_is_sd:            cu_immediate = w_imm_s;
                w_is_beq:           cu_immediate = w_imm_b;
                default:            cu_immediate = '0;
            endcase

            unique case (1'b1)
                w_is_beq: cu_alu_operation = ALU_SUB;
                w_is_r && (w_funct3 == 3'b111): cu_alu_operation = ALU_AND;
                w_is_r && (w_funct3 == 3'b110): cu_alu_operation = ALU_OR;
                w_is_r && w_funct7[5]:          cu_alu_operation = ALU_SUB;
                default:  cu_alu_operation = ALU_ADD;
            endcase
        end

        // x0 is hardwired, so a write to rd == 0 is suppressed here
        if (r_state == S_WB) begin
            cu_rf_write_en = (w_rd != 5'd0);
            cu_mux_2_sel   = w_is_ld;
        end
        if ((r_state == S_MEM) && w_is_sd) begin
            cu_dm_write_en = 1'b1;
        end
        if ((r_state == S_EXEC) && w_is_beq) begin
            cu_branch_taken = cu_alu_zero;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a stimulus process queues the expected
// per-instruction outcome, a negedge monitor collects and compares it.
module tb_control_unit;

    logic        cu_clk = 1'b0;
    logic        cu_rst_n = 1'b0;
    logic [31:0] cu_instr = '0;
    logic        cu_instr_valid = 1'b0;
    logic        cu_instr_ready;
    logic        cu_alu_zero = 1'b0;
    logic [4:0]  cu_rf_addr_a;
    logic [4:0]  cu_rf_addr_b;
    logic [4:0]  cu_rf_write_addr;
    logic        cu_rf_write_en;
    logic [63:0] cu_immediate;
    logic        cu_mux_0_sel;
    logic        cu_mux_1_sel;
    logic        cu_mux_2_sel;
    logic [2:0]  cu_alu_operation;
    logic        cu_dm_write_en;
    logic        cu_pc_en;
    logic        cu_branch_taken;
    logic        cu_illegal;
    logic [31:0] cu_retired_count;

    control_unit #(.WORDSIZE(64), .COUNTWIDTH(32)) dut (
        .cu_clk(cu_clk),
        .cu_rst_n(cu_rst_n),
        .cu_instr(cu_instr),
        .cu_instr_valid(cu_instr_valid),
        .cu_instr_ready(cu_instr_ready),
        .cu_alu_zero(cu_alu_zero),
        .cu_rf_addr_a(cu_rf_addr_a),
        .cu_rf_addr_b(cu_rf_addr_b),
        .cu_rf_write_addr(cu_rf_write_addr),
        .cu_rf_write_en(cu_rf_write_en),
        .cu_immediate(cu_immediate),
        .cu_mux_0_sel(cu_mux_0_sel),
        .cu_mux_1_sel(cu_mux_1_sel),
        .cu_mux_2_sel(cu_mux_2_sel),
        .cu_alu_operation(cu_alu_operation),
        .cu_dm_write_en(cu_dm_write_en),
        .cu_pc_en(cu_pc_en),
        .cu_branch_taken(cu_branch_taken),
        .cu_illegal(cu_illegal),
        .cu_retired_count(cu_retired_count)
    );

    always #5 cu_clk = ~cu_clk;

    typedef struct {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic [63:0] imm;
        logic        chk_imm;
        logic        mux1;
        logic [2:0]  alu;
        int          rfwe;
        int          dmwe;
        int          mux2;
        int          lat;
        logic        taken;
        logic        illegal;
        logic [31:0] count;
    } exp_t;

    exp_t        q[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] model_count = 0;
    bit          mon_off = 1'b1;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h", nm, act, exp);
    endtask

    function automatic logic [63:0] sext(input logic [63:0] v, input int bits);
        if (v[bits-1]) return v - (64'd1 << bits);
        return v;
    endfunction

    // Reference: outcome of one instruction from the ISA rules
    function automatic exp_t model(input logic [31:0] w, input logic z,
                                   input logic [31:0] cnt);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit ok;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        e = '{default: '0};
        e.count = cnt;
        e.ra = w[19:15];
        e.rb = w[24:20];
        e.wa = w[11:7];
        ok = 1'b1;
        if (op == 7'h03 && f3 == 3'd3) begin
            e.imm = sext(64'(w[31:20]), 12); e.chk_imm = 1;
            e.lat = 4; e.mux2 = 1; e.rfwe = (e.wa != 0) ? 1 : 0;
        end else if (op == 7'h23 && f3 == 3'd3) begin
            e.imm = sext(64'({w[31:25], w[11:7]}), 12); e.chk_imm = 1;
            e.lat = 3; e.dmwe = 1;
        end else if (op == 7'h13 && f3 == 3'd0) begin
            e.imm = sext(64'(w[31:20]), 12); e.chk_imm = 1;
            e.lat = 3; e.rfwe = (e.wa != 0) ? 1 : 0;
        end else if (op == 7'h63 && f3 == 3'd0) begin
            e.imm = sext(64'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
            e.chk_imm = 1; e.lat = 2; e.mux1 = 1; e.alu = 3'd1; e.taken = z;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h00) begin
            e.lat = 3; e.mux1 = 1; e.alu = 3'd0;
            e.rfwe = (e.wa != 0) ? 1 : 0;
        end else if (op == 7'h33 && f3 == 3'd0 && f7 == 7'h20) begin
            e.lat = 3; e.mux1 = 1; e.alu = 3'd1;
            e.rfwe = (e.wa != 0) ? 1 : 0;
        end else if (op == 7'h33 && (f3 == 3'd7 || f3 == 3'd6)) begin
            e.lat = 3; e.mux1 = 1; e.alu = (f3 == 3'd7) ? 3'd2 : 3'd3;
            e.rfwe = (e.wa != 0) ? 1 : 0;
        end else begin
            ok = 1'b0;
        end
        if (!ok) begin
            e = '{default: '0};
            e.count = cnt;
            e.illegal = 1;
            e.lat = 1;
        end
        return e;
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 20 && !cu_instr_ready; k++) begin
            @(posedge cu_clk); #1;
        end
        if (!cu_instr_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic issue(input logic [31:0] w, input logic z);
        exp_t e;
        wait_ready();
        e = model(w, z, model_count);
        if (!e.illegal) model_count++;
        q.push_back(e);
        cu_instr = w;
        cu_alu_zero = z;
        cu_instr_valid = 1'b1;
        @(posedge cu_clk); #1;
        cu_instr_valid = 1'b0;
        cu_instr = $urandom;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] im;
        logic [12:0] b;
        logic [2:0]  f3;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        im = 12'($urandom);
        b = {13'($urandom) & 13'h1FFE};
        unique case ($urandom_range(0, 6))
            0: return {im, rs1, 3'b011, rd, 7'h03};
            1: return {im[11:5], rs2, rs1, 3'b011, im[4:0], 7'h23};
            2: return {im, rs1, 3'b000, rd, 7'h13};
            3: begin
                f3 = ($urandom_range(0, 2) == 0) ? 3'd7 :
                     ($urandom_range(0, 1) == 0) ? 3'd6 : 3'd0;
                return {($urandom_range(0, 1) == 1 && f3 == 3'd0) ?
                        7'h20 : 7'h00, rs2, rs1, f3, rd, 7'h33};
            end
            4: return {b[12], b[10:5], rs2, rs1, 3'b000, b[4:1], b[11], 7'h63};
            5: return {7'h01, rs2, rs1, 3'($urandom), rd, 7'h33};
            default: return $urandom;
        endcase
    endfunction

    // Monitor
    bit busy = 0;
    int cyc, n_rfwe, n_dmwe, n_mux2, n_mux0;
    always @(negedge cu_clk) begin
        exp_t e;
        if (mon_off || !cu_rst_n) begin
            busy = 0;
        end else begin
            if (busy) begin
                cyc++;
                n_rfwe += int'(cu_rf_write_en);
                n_dmwe += int'(cu_dm_write_en);
                n_mux2 += int'(cu_mux_2_sel);
                n_mux0 += int'(cu_mux_0_sel);
                if (cu_pc_en || cu_illegal) begin
                    busy = 0;
                    if (q.size() == 0) begin
                        chk("unexpected_event", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk("illegal", cu_illegal, e.illegal);
                        chk("pc_en", cu_pc_en, !e.illegal);
                        chk("latency", cyc, e.lat);
                        chk("count", cu_retired_count, e.count);
                        chk("rf_write_en_cycles", n_rfwe, e.rfwe);
                        chk("dm_write_en_cycles", n_dmwe, e.dmwe);
                        chk("mux_2_cycles", n_mux2, e.mux2);
                        if (!e.illegal) begin
                            chk("addr_a", cu_rf_addr_a, e.ra);
                            chk("addr_b", cu_rf_addr_b, e.rb);
                            chk("write_addr", cu_rf_write_addr, e.wa);
                            chk("mux_0", n_mux0, 0);
                            chk("mux_1", cu_mux_1_sel, e.mux1);
                            chk("alu_op", cu_alu_operation, e.alu);
                            chk("branch_taken", cu_branch_taken, e.taken);
                            if (e.chk_imm) chk("immediate", cu_immediate, e.imm);
                        end
                    end
                end else if (cyc > 6) begin
                    chk("busy_timeout", 1, 0);
                    busy = 0;
                end
            end
            if (cu_instr_ready && cu_instr_valid) begin
                busy = 1;
                cyc = 0; n_rfwe = 0; n_dmwe = 0; n_mux2 = 0; n_mux0 = 0;
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 50 && q.size() != 0; k++) @(posedge cu_clk);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        wait_ready();
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_ready"}, cu_instr_ready, 1);
        chk({tag, "_count"}, cu_retired_count, 0);
        chk({tag, "_outs"}, {cu_rf_addr_a, cu_rf_addr_b, cu_rf_write_addr,
            cu_rf_write_en, cu_mux_0_sel, cu_mux_1_sel, cu_mux_2_sel,
            cu_alu_operation, cu_dm_write_en, cu_pc_en, cu_branch_taken,
            cu_illegal}, 0);
        chk({tag, "_imm"}, cu_immediate, 0);
    endtask

    initial begin
        repeat (2) @(posedge cu_clk);
        #1;
        chk_idle("reset");
        cu_rst_n = 1'b1;
        mon_off = 1'b0;

        issue(32'h0053B103, 1'b0);
        issue(32'h002081B3, 1'b0);
        issue(32'h402081B3, 1'b0);
        issue(32'hFE533C23, 1'b0);
        issue(32'h00208863, 1'b1);
        issue(32'h00208863, 1'b0);
        issue(32'h00000000, 1'b0);
        issue(32'h00108013, 1'b0);
        for (int i = 0; i < 300; i++) issue(rand_instr(), 1'($urandom));
        drain();

        // Reset in the MEM cycle of a store
        mon_off = 1'b1;
        cu_instr = 32'hFE533C23;
        cu_instr_valid = 1'b1;
        @(posedge cu_clk); #1;
        cu_instr_valid = 1'b0;
        repeat (2) @(posedge cu_clk);
        #1;
        chk("mem_dm_write_en", cu_dm_write_en, 1);
        cu_rst_n = 1'b0;
        @(posedge cu_clk); #1;
        chk_idle("midreset");
        cu_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge cu_clk); #1;
            chk("idle_hold_ready", cu_instr_ready, 1);
            chk("idle_hold_dm", cu_dm_write_en, 0);
        end

        model_count = 0;
        mon_off = 1'b0;
        issue(32'h0053B103, 1'b0);
        drain();
        chk("final_count", cu_retired_count, model_count);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
